// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the inst/data request arbiter in front of axi_bridge.
package mem_arb_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  // Access size codes understood by axi_bridge.
  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = 4;
  localparam int unsigned SIZE_W  = 3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  // One SRAM-like request as presented to the bridge.
  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Round-robin pick: a lone requester wins, a conflict goes to the one not granted last.
  function automatic logic rr_pick(input logic i_req, input logic d_req, input logic last);
    if (i_req && d_req) return ~last;
    if (d_req)          return SRC_DATA;
    return SRC_INST;
  endfunction

endpackage

// File: rtl/arb_order_fifo.sv
// 1-bit in-order FIFO recording which requester owns each outstanding request.
module arb_order_fifo #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          din,
  output logic          head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Storage, wrapping pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == CW'(0));

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing the axi_bridge SRAM-like port between inst and data requesters.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [2:0]  i_size,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_wstrb,
  input  logic [31:0] i_wdata,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [2:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [2:0]  m_size,
  output logic [31:0] m_addr,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic        err_orphan
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;

  arb_state_e  state, state_nxt;
  logic        hold_src, hold_src_nxt;
  logic        last_grant, last_grant_nxt;
  logic        err_nxt;
  logic        sel, sel_req, fwd, accept, pop;
  logic        fifo_full, fifo_empty, fifo_head;
  logic [CW-1:0] fifo_count;
  req_t        i_pkt, d_pkt, m_pkt;

  assign i_pkt = '{wr: i_wr, size: i_size, addr: i_addr, wstrb: i_wstrb, wdata: i_wdata};
  assign d_pkt = '{wr: d_wr, size: d_size, addr: d_addr, wstrb: d_wstrb, wdata: d_wdata};

  // A response pops the owner only if one is recorded; otherwise it is an orphan.
  assign pop = aresetn && m_data_ok && !fifo_empty;

  // Source selection, forwarding gate, FSM next state and bookkeeping.
  always_comb begin
    state_nxt      = state;
    hold_src_nxt   = hold_src;
    last_grant_nxt = last_grant;
    err_nxt        = err_orphan;
    sel            = rr_pick(i_req, d_req, last_grant);
    sel_req        = i_req || d_req;
    if (state == ARB_HOLD) begin
      sel     = hold_src;
      sel_req = (hold_src == SRC_DATA) ? d_req : i_req;
    end
    // A full FIFO blocks forwarding unless a pop frees a slot this same cycle.
    fwd    = aresetn && sel_req && !(fifo_full && !pop);
    accept = fwd && m_addr_ok;
    case (state)
      ARB_IDLE: if (fwd && !m_addr_ok) begin
        state_nxt    = ARB_HOLD;
        hold_src_nxt = sel;
      end
      ARB_HOLD: if (accept) state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
    if (accept) last_grant_nxt = sel;
    if (m_data_ok && fifo_empty) err_nxt = 1'b1;
  end

  // Arbiter state, round-robin history and sticky orphan flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= ARB_IDLE;
      hold_src   <= SRC_INST;
      last_grant <= SRC_INST;
      err_orphan <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_src   <= hold_src_nxt;
      last_grant <= last_grant_nxt;
      err_orphan <= err_nxt;
    end
  end

  arb_order_fifo #(.DEPTH(MAX_OUTSTANDING)) u_order_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (accept),
    .pop   (pop),
    .din   (sel),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Occupancy can never exceed the configured depth.
  a_count_bound : assert property (@(posedge aclk) disable iff (!aresetn)
    fifo_count <= CW'(MAX_OUTSTANDING));

  // Steering of the selected request to the bridge and responses back to the owner.
  assign m_pkt     = aresetn ? ((sel == SRC_DATA) ? d_pkt : i_pkt) : '0;
  assign m_req     = fwd;
  assign m_wr      = m_pkt.wr;
  assign m_size    = m_pkt.size;
  assign m_addr    = m_pkt.addr;
  assign m_wstrb   = m_pkt.wstrb;
  assign m_wdata   = m_pkt.wdata;
  assign i_addr_ok = accept && (sel == SRC_INST);
  assign d_addr_ok = accept && (sel == SRC_DATA);
  assign i_data_ok = pop && (fifo_head == SRC_INST);
  assign d_data_ok = pop && (fifo_head == SRC_DATA);
  assign i_rdata   = aresetn ? m_rdata : '0;
  assign d_rdata   = aresetn ? m_rdata : '0;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a queue-based reference model checked every cycle.
module tb_mem_req_arbiter;

  localparam int MAXO = 4;

  logic        aclk, aresetn;
  logic        i_req, i_wr, d_req, d_wr;
  logic [2:0]  i_size, d_size, m_size;
  logic [31:0] i_addr, d_addr, i_wdata, d_wdata, m_addr, m_wdata;
  logic [3:0]  i_wstrb, d_wstrb, m_wstrb;
  logic        i_addr_ok, d_addr_ok, i_data_ok, d_data_ok;
  logic [31:0] i_rdata, d_rdata, m_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok, err_orphan;

  int total = 0;
  int bad   = 0;

  mem_req_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr),
    .i_wstrb(i_wstrb), .i_wdata(i_wdata),
    .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
    .d_wstrb(d_wstrb), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wstrb(m_wstrb), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .err_orphan(err_orphan)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: ordered list of owners, last winner, pending held source, orphan flag.
  int q[$];
  int last_g = 0;
  int held   = -1;
  bit orphan = 1'b0;

  always @(negedge aclk) begin
    int  s;
    bit  want, popping, mreq;
    int  h;
    if (!aresetn) begin
      chk("rst_m_req", 32'(m_req), 32'd0);
      chk("rst_any_out", 32'(|{m_wr, m_size, m_addr, m_wstrb, m_wdata, i_addr_ok, d_addr_ok,
                               i_data_ok, d_data_ok, i_rdata, d_rdata}), 32'd0);
      chk("rst_err", 32'(err_orphan), 32'd0);
      q.delete();
      last_g = 0;
      held   = -1;
      orphan = 1'b0;
    end else begin
      if (held >= 0) begin
        s = held; want = 1'b1;
      end else begin
        want = i_req || d_req;
        if (i_req && d_req) s = (last_g == 0) ? 1 : 0;
        else                s = d_req ? 1 : 0;
      end
      popping = m_data_ok && (q.size() > 0);
      mreq    = want && ((q.size() < MAXO) || popping);
      h       = popping ? q[0] : -1;
      chk("m_req", 32'(m_req), 32'(mreq));
      chk("i_addr_ok", 32'(i_addr_ok), 32'(mreq && m_addr_ok && s == 0));
      chk("d_addr_ok", 32'(d_addr_ok), 32'(mreq && m_addr_ok && s == 1));
      chk("i_data_ok", 32'(i_data_ok), 32'(h == 0));
      chk("d_data_ok", 32'(d_data_ok), 32'(h == 1));
      chk("i_rdata", i_rdata, m_rdata);
      chk("d_rdata", d_rdata, m_rdata);
      chk("err_orphan", 32'(err_orphan), 32'(orphan));
      if (mreq) begin
        chk("m_addr",  m_addr,  s ? d_addr  : i_addr);
        chk("m_wdata", m_wdata, s ? d_wdata : i_wdata);
        chk("m_ctrl",  32'({m_wr, m_size, m_wstrb}),
            32'(s ? {d_wr, d_size, d_wstrb} : {i_wr, i_size, i_wstrb}));
      end
      if (m_data_ok && q.size() == 0) orphan = 1'b1;
      if (popping) void'(q.pop_front());
      if (mreq && m_addr_ok) begin
        q.push_back(s);
        last_g = s;
        held   = -1;
      end else if (mreq) begin
        held = s;
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge aclk);
  endtask

  initial begin
    aresetn = 1'b0;
    {i_req, i_wr, d_req, d_wr, m_addr_ok, m_data_ok} = '0;
    {i_size, d_size} = '0;
    {i_addr, d_addr, i_wdata, d_wdata, m_rdata} = '0;
    {i_wstrb, d_wstrb} = '0;
    i_req = 1'b1; m_addr_ok = 1'b1;
    at_neg();
    chk("lit_rst_m_req", 32'(m_req), 32'd0);
    chk("lit_rst_addr_ok", 32'(i_addr_ok), 32'd0);
    tick();
    aresetn = 1'b1; i_req = 1'b0; m_addr_ok = 1'b0;
    tick();

    // Lone inst read.
    i_req = 1'b1; i_addr = 32'h1C00_0000; i_size = 3'd2; m_addr_ok = 1'b1;
    at_neg();
    chk("lit_lone_addr_ok", 32'(i_addr_ok), 32'd1);
    chk("lit_lone_m_addr", m_addr, 32'h1C00_0000);
    chk("lit_lone_d_addr_ok", 32'(d_addr_ok), 32'd0);
    tick();
    i_req = 1'b0; m_addr_ok = 1'b0;
    tick();
    m_data_ok = 1'b1; m_rdata = 32'h0280_0C00;
    at_neg();
    chk("lit_lone_data_ok", 32'(i_data_ok), 32'd1);
    chk("lit_lone_rdata", i_rdata, 32'h0280_0C00);
    chk("lit_lone_d_data_ok", 32'(d_data_ok), 32'd0);
    tick();
    m_data_ok = 1'b0;

    // Conflict: data wins first, then inst; responses route in order.
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h1C00_0100; d_addr = 32'h0000_1000; m_addr_ok = 1'b1;
    at_neg();
    chk("lit_conf_d_first", 32'(d_addr_ok), 32'd1);
    chk("lit_conf_i_wait", 32'(i_addr_ok), 32'd0);
    tick();
    d_req = 1'b0;
    at_neg();
    chk("lit_conf_i_second", 32'(i_addr_ok), 32'd1);
    tick();
    i_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'hA;
    at_neg();
    chk("lit_conf_rsp_d", 32'(d_data_ok), 32'd1);
    chk("lit_conf_rdata_a", d_rdata, 32'hA);
    tick();
    m_rdata = 32'hB;
    at_neg();
    chk("lit_conf_rsp_i", 32'(i_data_ok), 32'd1);
    tick();
    m_data_ok = 1'b0;

    // Lone data write so that data is the last grant.
    d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
    m_addr_ok = 1'b1;
    at_neg();
    chk("lit_wr_m_wdata", m_wdata, 32'hDEAD_BEEF);
    tick();
    d_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
    at_neg();
    chk("lit_wr_rsp_d", 32'(d_data_ok), 32'd1);
    tick();
    m_data_ok = 1'b0; d_wr = 1'b0; d_wstrb = 4'h0;

    // HOLD: data stalled by the bridge stays selected while inst rises.
    d_req = 1'b1; d_addr = 32'h0000_2010;
    at_neg();
    chk("lit_hold_m_addr0", m_addr, 32'h0000_2010);
    tick();
    i_req = 1'b1; i_addr = 32'h1C00_0200;
    for (int k = 0; k < 2; k++) begin
      at_neg();
      chk("lit_hold_m_addr", m_addr, 32'h0000_2010);
      tick();
    end
    m_addr_ok = 1'b1;
    at_neg();
    chk("lit_hold_accept_d", 32'(d_addr_ok), 32'd1);
    tick();
    d_req = 1'b0;
    at_neg();
    chk("lit_hold_then_i", 32'(i_addr_ok), 32'd1);
    tick();
    i_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
    at_neg();
    chk("lit_hold_rsp_d", 32'(d_data_ok), 32'd1);
    tick();
    at_neg();
    chk("lit_hold_rsp_i", 32'(i_data_ok), 32'd1);
    tick();
    m_data_ok = 1'b0;

    // Full FIFO: four accepts, then blocked until a same-cycle response frees a slot.
    i_req = 1'b1; m_addr_ok = 1'b1;
    for (int k = 0; k < MAXO; k++) begin
      i_addr = 32'h1C00_1000 + 32'(4 * k);
      at_neg();
      chk("lit_full_fill", 32'(i_addr_ok), 32'd1);
      tick();
    end
    at_neg();
    chk("lit_full_m_req", 32'(m_req), 32'd0);
    chk("lit_full_addr_ok", 32'(i_addr_ok), 32'd0);
    tick();
    m_data_ok = 1'b1;
    at_neg();
    chk("lit_full_swap_accept", 32'(i_addr_ok), 32'd1);
    chk("lit_full_swap_rsp", 32'(i_data_ok), 32'd1);
    tick();
    m_data_ok = 1'b0;
    at_neg();
    chk("lit_full_still_full", 32'(m_req), 32'd0);
    tick();
    i_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
    for (int k = 0; k < MAXO; k++) begin
      at_neg();
      chk("lit_full_drain", 32'(i_data_ok), 32'd1);
      tick();
    end

    // Orphan response with nothing outstanding.
    at_neg();
    chk("lit_orph_i", 32'(i_data_ok), 32'd0);
    chk("lit_orph_d", 32'(d_data_ok), 32'd0);
    chk("lit_orph_err_pre", 32'(err_orphan), 32'd0);
    tick();
    m_data_ok = 1'b0;
    at_neg();
    chk("lit_orph_err_set", 32'(err_orphan), 32'd1);
    tick();
    tick();
    at_neg();
    chk("lit_orph_err_sticky", 32'(err_orphan), 32'd1);

    // Reset with two outstanding (inst then data, so data is last grant).
    tick();
    i_req = 1'b1; m_addr_ok = 1'b1;
    at_neg();
    chk("lit_rm_i_acc", 32'(i_addr_ok), 32'd1);
    tick();
    i_req = 1'b0; d_req = 1'b1;
    at_neg();
    chk("lit_rm_d_acc", 32'(d_addr_ok), 32'd1);
    tick();
    aresetn = 1'b0; i_req = 1'b1; d_req = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h1234_5678;
    at_neg();
    chk("lit_rm_m_req", 32'(m_req), 32'd0);
    chk("lit_rm_data_ok", 32'({i_data_ok, d_data_ok}), 32'd0);
    chk("lit_rm_err", 32'(err_orphan), 32'd0);
    chk("lit_rm_rdata", i_rdata, 32'd0);
    tick();
    aresetn = 1'b1; i_req = 1'b0; d_req = 1'b0; m_addr_ok = 1'b0;
    at_neg();
    chk("lit_rm_empty", 32'({i_data_ok, d_data_ok}), 32'd0);
    tick();
    m_data_ok = 1'b0; i_req = 1'b1; d_req = 1'b1; m_addr_ok = 1'b1;
    at_neg();
    chk("lit_rm_conf_d", 32'(d_addr_ok), 32'd1);
    tick();
    d_req = 1'b0;
    at_neg();
    chk("lit_rm_conf_i", 32'(i_addr_ok), 32'd1);
    tick();
    i_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
    tick();
    tick();
    m_data_ok = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
